debounce_edge: RTL and testbench

Conditions one asynchronous, possibly bouncy single-bit input (switch, button, external strobe) so downstream `D_ff`-based sequential logic receives a clean, clock-synchronous level. Synchronizes the input through two flip-flops and accepts a new level only after it has been stable for `STABLE_CYCLES` consecutive samples. Emits the debounced level plus one-cycle rise/fall pulses. Sits directly upstream of the basic sequential stages and feeds their `D` input.

---
 rtl/debounce_edge_pkg.sv | 9 +
 rtl/debounce_edge_d_ff_r.sv | 18 +
 rtl/debounce_edge.sv | 104 ++++++++++
 tb/tb_debounce_edge.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/debounce_edge_pkg.sv
// Shared types for the debounce_edge block: the two-state qualification FSM encoding.
package debounce_edge_pkg;

    typedef enum logic {
        ST_STABLE   = 1'b0,
        ST_COUNTING = 1'b1
    } state_e;

endpackage

// File: rtl/debounce_edge_d_ff_r.sv
// Plain D flip-flop with asynchronous active-low reset to a parameterised level.
// Used for the input synchronizer and reusable by downstream sequential stages.
module d_ff_r #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    // NOTE: state flops always use non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q <= RESET_VAL;
        else        q <= d;
    end

endmodule

// File: rtl/debounce_edge.sv
// Two-flop synchronizer plus stability-qualification FSM for a bouncy asynchronous input;
// produces a clean registered level and one-cycle rise/fall pulses.
module debounce_edge
    import debounce_edge_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 3,
    parameter logic        RESET_LEVEL   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic s1;
    logic s2;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             dout_q,  dout_d;
    logic             rise_q,  rise_d;
    logic             fall_q,  fall_d;

    d_ff_r #(.RESET_VAL(RESET_LEVEL)) u_sync1 (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (din),
        .q     (s1)
    );

    d_ff_r #(.RESET_VAL(RESET_LEVEL)) u_sync2 (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (s1),
        .q     (s2)
    );

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;

        case (state_q)
            ST_STABLE: begin
                if (s2 != dout_q) begin
                    state_d = ST_COUNTING;
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d   = '0;
                end
            end
            ST_COUNTING: begin
                if (s2 == dout_q) begin
                    // Candidate reverted before qualifying: drop it silently.
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                    dout_d  = s2;
                    rise_d  = s2;
                    fall_d  = ~s2;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_STABLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_STABLE;
            cnt_q   <= '0;
            dout_q  <= RESET_LEVEL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign dout = dout_q;
    assign rise = rise_q;
    assign fall = fall_q;
    assign busy = (state_q == ST_COUNTING);

endmodule

// File: tb/tb_debounce_edge.sv
// Self-checking bench for debounce_edge: vector table, hand-written corner sequences,
// and randomized input runs compared against a sliding-window reference model.
module tb_debounce_edge;

    localparam int N = 4;

    logic clk;
    logic rst_n;
    logic din;
    logic dout;
    logic rise;
    logic fall;
    logic busy;

    int n_cmp;
    int n_mis;

    debounce_edge #(
        .STABLE_CYCLES (N),
        .CNT_W         (3),
        .RESET_LEVEL   (1'b0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (din),
        .dout  (dout),
        .rise  (rise),
        .fall  (fall),
        .busy  (busy)
    );

    initial begin
        clk = 1'b0;
        forever #10ns clk = ~clk;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, summary not printed normally");
        $fatal(1, "watchdog");
    end

    // Reference model: hist_m[0] is the din value sampled at the latest edge. The level
    // the debouncer sees at an edge is din from two edges earlier (hist_m[1] before the
    // edge). A new level is accepted once the last N such observations all disagree
    // with the current output.
    logic [7:0] hist_m;
    logic       dout_m;
    logic       rise_m;
    logic       fall_m;
    logic       busy_m;
    logic       m_accept;
    logic       m_dout_nx;

    assign m_accept  = (hist_m[N:1] == {N{~dout_m}});
    assign m_dout_nx = dout_m ^ m_accept;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_m <= '0;
            dout_m <= 1'b0;
            rise_m <= 1'b0;
            fall_m <= 1'b0;
            busy_m <= 1'b0;
        end else begin
            hist_m <= {hist_m[6:0], din};
            dout_m <= m_dout_nx;
            rise_m <= m_accept & ~dout_m;
            fall_m <= m_accept & dout_m;
            busy_m <= (hist_m[1] != m_dout_nx);
        end
    end

    typedef struct packed {
        logic       din;
        logic [3:0] exp;   // {dout, rise, fall, busy} after the next edge
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic d, input logic [3:0] e);
        vec_t v;
        v.din = d;
        v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got {dout,rise,fall,busy}=%b, expected %b (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    initial begin
        int run;
        n_cmp = 0;
        n_mis = 0;

        // Clean rise from idle: edge k is the first row's edge; dout flips at k+5.
        add(1, 4'b0000); add(1, 4'b0000); add(1, 4'b0001); add(1, 4'b0001);
        add(1, 4'b0001); add(1, 4'b1100); add(1, 4'b1000);
        // Clean fall from a stable 1.
        add(0, 4'b1000); add(0, 4'b1000); add(0, 4'b1001); add(0, 4'b1001);
        add(0, 4'b1001); add(0, 4'b0010); add(0, 4'b0000);
        // High for 3 sampled edges: rejected.
        add(1, 4'b0000); add(1, 4'b0000); add(1, 4'b0001); add(0, 4'b0001);
        add(0, 4'b0001); add(0, 4'b0000); add(0, 4'b0000);
        // High for 4 sampled edges: accepted, then the low level qualifies back.
        add(1, 4'b0000); add(1, 4'b0000); add(1, 4'b0001); add(1, 4'b0001);
        add(0, 4'b0001); add(0, 4'b1100); add(0, 4'b1001); add(0, 4'b1001);
        add(0, 4'b1001); add(0, 4'b0010); add(0, 4'b0000);

        // Reset held with din high.
        rst_n = 1'b0;
        din   = 1'b1;
        #1ns;
        check("reset_t0", {dout, rise, fall, busy}, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("reset_hold[%0d]", i), {dout, rise, fall, busy}, 4'b0000);
        end
        rst_n = 1'b1;
        din   = 1'b0;
        repeat (3) @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            din = vecs[i].din;
            @(negedge clk);
            check($sformatf("tbl[%0d]", i), {dout, rise, fall, busy}, vecs[i].exp);
        end

        // Asynchronous reset in the middle of a high clock phase, while rise is asserted.
        din = 1'b1;
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1ns;
        check("async_pre", {dout, rise, fall, busy}, 4'b1100);
        #2ns;
        rst_n = 1'b0;
        #1ns;
        check("async_clear", {dout, rise, fall, busy}, 4'b0000);
        @(negedge clk);
        din   = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Bounce train: 10 toggles two cycles apart, then a final hold at 1.
        for (int t = 0; t < 10; t++) begin
            din = ~din;
            for (int c = 0; c < 2; c++) begin
                @(negedge clk);
                check($sformatf("bounce[%0d.%0d]", t, c), {dout, rise, fall, 1'b0}, 4'b0000);
            end
        end
        din = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check($sformatf("bounce_final[k+%0d]", i), {dout, rise, fall, 1'b0},
                  {(i >= 5), (i == 5), 1'b0, 1'b0});
        end

        // Return to 0, then reset while a rise candidate is being qualified.
        din = 1'b0;
        repeat (8) @(negedge clk);
        check("midcnt_idle", {dout, rise, fall, busy}, 4'b0000);
        din = 1'b1;
        repeat (3) @(negedge clk);
        check("midcnt_busy", {dout, rise, fall, busy}, 4'b0001);
        rst_n = 1'b0;
        din   = 1'b0;
        @(negedge clk);
        check("midcnt_in_reset", {dout, rise, fall, busy}, 4'b0000);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("midcnt_after[%0d]", i), {dout, rise, fall, busy}, 4'b0000);
        end

        // Randomized runs of random length against the reference model.
        for (int r = 0; r < 300; r++) begin
            din = $urandom_range(0, 1);
            run = $urandom_range(1, 7);
            for (int c = 0; c < run; c++) begin
                @(negedge clk);
                check($sformatf("rand[%0d.%0d]", r, c), {dout, rise, fall, busy},
                      {dout_m, rise_m, fall_m, busy_m});
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
